// File: rtl/uart_rx_if.sv
// uart_rx_if -- consumer-side bundle of the UART receiver.
//   rx_data      byte last received with a good stop bit
//   rx_valid     rx_data holds an unconsumed byte
//   rx_ack       consumer pulse, clears rx_valid / rx_overrun
//   rx_frame_err one-cycle pulse on a low stop bit
//   rx_overrun   sticky, a byte was dropped while rx_valid was held
//   rx_busy      receiver is somewhere inside a frame
// master = receiver side, slave = consumer side.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   modport master (output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
                   input  rx_ack);
   modport slave  (input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
                   output rx_ack);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver with a one-entry holding
// register and valid/ack handshake.
//   clk     block clock (CLK_SPEED Hz)
//   rstz    asynchronous active-low reset
//   rxd     serial line, asynchronous, idles high
//   rx_bus  uart_rx_if.master: rx_data/rx_valid/rx_ack/rx_frame_err/
//           rx_overrun/rx_busy
module uart_rx #(
   parameter int CLK_SPEED = 100_000_000,
   parameter int BAUDRATE  = 115200
) (
   input  logic      clk,
   input  logic      rstz,
   input  logic      rxd,
   uart_rx_if.master rx_bus
);

   localparam int CLKS_PER_BIT = CLK_SPEED / BAUDRATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t           state_q;
   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_q;
   logic             valid_q, ferr_q, ovr_q, busy_q;

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q <= IDLE;
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q   <= rxd;
         s2_q   <= s1_q;
         ferr_q <= 1'b0;
         cnt_q  <= cnt_q + CNT_W'(1);

         // Ack clears the handshake; a delivery below overrides this.
         if (rx_bus.rx_ack) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!s2_q) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == CNT_HALF) begin
                  if (!s2_q) begin
                     cnt_q   <= '0;
                     idx_q   <= '0;
                     state_q <= DATA;
                  end else begin
                     // line went back high before mid start bit: glitch
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (cnt_q == CNT_FULL) begin
                  shift_q[idx_q] <= s2_q;
                  cnt_q          <= '0;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               // Sampled mid stop bit, so an immediately following start
               // bit is still seen from IDLE.
               if (cnt_q == CNT_FULL) begin
                  if (s2_q) begin
                     valid_q <= 1'b1;
                     if (!valid_q || rx_bus.rx_ack) data_q <= shift_q;
                     else                           ovr_q  <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               // a break holds the line low; never restart until it idles
               if (s2_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_bus.rx_data      = data_q;
   assign rx_bus.rx_valid     = valid_q;
   assign rx_bus.rx_frame_err = ferr_q;
   assign rx_bus.rx_overrun   = ovr_q;
   assign rx_bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scenario-driven bench for uart_rx at 16 clocks per bit.
// Bytes expected to be delivered are queued when the frame is sent and
// popped when rx_valid shows the byte.
module tb_uart_rx;
   logic clk = 1'b0;
   logic rstz = 1'b0;
   logic rxd = 1'b1;
   int   tests_run = 0;
   int   fails = 0;
   logic [7:0] exp_q[$];

   uart_rx_if bus();

   uart_rx #(.CLK_SPEED(1_600_000), .BAUDRATE(100_000)) dut (
      .clk    (clk),
      .rstz   (rstz),
      .rxd    (rxd),
      .rx_bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // 10 bits, 16 cycles each, each bit driven 1 time unit after a posedge
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 rxd = bits[i];
         repeat (15) @(posedge clk);
      end
   endtask

   task automatic do_ack();
      @(posedge clk); #1 bus.rx_ack = 1'b1;
      @(posedge clk); #1 bus.rx_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.rx_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.rx_ack = 1'b0;
      rxd = 1'b1;
      rstz = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({bus.rx_data, bus.rx_valid, bus.rx_frame_err, bus.rx_overrun, bus.rx_busy} !== 12'h000) begin
         fails++;
         $display("FAIL reset_state: got data=%h v=%b fe=%b ov=%b busy=%b want all 0",
                  bus.rx_data, bus.rx_valid, bus.rx_frame_err, bus.rx_overrun, bus.rx_busy);
      end
      @(posedge clk); #1 rstz = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_good_frame();
      logic v154, v155, fe, ov;
      logic [7:0] d, e;
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            @(posedge clk);
            for (int k = 1; k <= 155; k++) begin
               @(posedge clk); @(negedge clk);
               if (k == 154) v154 = bus.rx_valid;
               if (k == 155) begin
                  v155 = bus.rx_valid; d = bus.rx_data;
                  fe = bus.rx_frame_err; ov = bus.rx_overrun;
               end
            end
         end
      join
      tests_run++;
      if (v154 !== 1'b0 || v155 !== 1'b1) begin
         fails++;
         $display("FAIL good_latency: valid@154=%b valid@155=%b want 0,1", v154, v155);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e || fe !== 1'b0 || ov !== 1'b0) begin
         fails++;
         $display("FAIL good_data: data=%h fe=%b ov=%b want data=%h fe=0 ov=0", d, fe, ov, e);
      end
      do_ack();
      tests_run++;
      if (bus.rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL good_ack: valid=%b want 0", bus.rx_valid);
      end
   endtask

   task automatic test_glitch();
      int busy_n = 0, flags = 0;
      fork
         begin
            @(posedge clk); #1 rxd = 1'b0;
            repeat (4) @(posedge clk); #1 rxd = 1'b1;
         end
         begin
            @(posedge clk);
            repeat (40) begin
               @(negedge clk);
               if (bus.rx_busy) busy_n++;
               if (bus.rx_valid || bus.rx_frame_err || bus.rx_overrun) flags++;
            end
         end
      join
      tests_run++;
      if (busy_n != 8) begin
         fails++;
         $display("FAIL glitch_busy: busy cycles=%0d want 8", busy_n);
      end
      tests_run++;
      if (flags != 0) begin
         fails++;
         $display("FAIL glitch_flags: flag cycles=%0d want 0", flags);
      end
   endtask

   task automatic test_frame_err();
      int fe_n = 0, v_n = 0;
      logic busy_low;
      bit ok;
      logic [7:0] e;
      fork
         begin
            send_frame(8'h3C, 1'b0);
            repeat (40) @(posedge clk);
            @(negedge clk); busy_low = bus.rx_busy;
            @(posedge clk); #1 rxd = 1'b1;
         end
         begin
            repeat (215) begin
               @(negedge clk);
               if (bus.rx_frame_err) fe_n++;
               if (bus.rx_valid) v_n++;
            end
         end
      join
      tests_run++;
      if (fe_n != 1 || v_n != 0) begin
         fails++;
         $display("FAIL frame_err_pulse: fe cycles=%0d valid cycles=%0d want 1,0", fe_n, v_n);
      end
      tests_run++;
      if (busy_low !== 1'b1 || bus.rx_busy !== 1'b0) begin
         fails++;
         $display("FAIL break_busy: busy in break=%b after=%b want 1,0", busy_low, bus.rx_busy);
      end
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      wait_valid(20, ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || bus.rx_data !== e || bus.rx_frame_err !== 1'b0) begin
         fails++;
         $display("FAIL after_break: ok=%b data=%h fe=%b want ok=1 data=%h fe=0",
                  ok, bus.rx_data, bus.rx_frame_err, e);
      end
      do_ack();
   endtask

   task automatic test_overrun();
      logic [7:0] e;
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      repeat (3) @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (bus.rx_data !== e || bus.rx_valid !== 1'b1 || bus.rx_overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun: data=%h v=%b ov=%b want data=%h v=1 ov=1",
                  bus.rx_data, bus.rx_valid, bus.rx_overrun, e);
      end
      do_ack();
      tests_run++;
      if (bus.rx_valid !== 1'b0 || bus.rx_overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_ack: v=%b ov=%b want 0,0", bus.rx_valid, bus.rx_overrun);
      end
   endtask

   task automatic test_ack_coincident();
      bit ok;
      logic [7:0] e;
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1);
      wait_valid(20, ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || bus.rx_data !== e) begin
         fails++;
         $display("FAIL coincident_first: ok=%b data=%h want ok=1 data=%h", ok, bus.rx_data, e);
      end
      exp_q.push_back(8'h02);
      fork
         send_frame(8'h02, 1'b1);
         begin
            @(posedge clk);
            repeat (154) @(posedge clk);
            #1 bus.rx_ack = 1'b1;
            @(posedge clk); #1 bus.rx_ack = 1'b0;
         end
      join
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (bus.rx_data !== e || bus.rx_valid !== 1'b1 || bus.rx_overrun !== 1'b0) begin
         fails++;
         $display("FAIL coincident_ack: data=%h v=%b ov=%b want data=%h v=1 ov=0",
                  bus.rx_data, bus.rx_valid, bus.rx_overrun, e);
      end
      do_ack();
   endtask

   task automatic test_reset_mid_frame();
      logic [11:0] snap;
      int v_n = 0;
      bit ok;
      logic [7:0] e;
      fork
         send_frame(8'h7E, 1'b1);
         begin
            @(posedge clk);
            repeat (70) @(posedge clk);
            #1 rstz = 1'b0;
            #2 snap = {bus.rx_data, bus.rx_valid, bus.rx_frame_err, bus.rx_overrun, bus.rx_busy};
            repeat (100) @(posedge clk);
            #1 rstz = 1'b1;
         end
      join
      tests_run++;
      if (snap !== 12'h000) begin
         fails++;
         $display("FAIL reset_async: outputs=%h want 000", snap);
      end
      repeat (30) begin
         @(negedge clk);
         if (bus.rx_valid || bus.rx_busy) v_n++;
      end
      tests_run++;
      if (v_n != 0) begin
         fails++;
         $display("FAIL reset_no_delivery: valid/busy cycles=%0d want 0", v_n);
      end
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1);
      wait_valid(20, ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || bus.rx_data !== e || bus.rx_frame_err !== 1'b0 || bus.rx_overrun !== 1'b0) begin
         fails++;
         $display("FAIL after_reset: ok=%b data=%h fe=%b ov=%b want ok=1 data=%h fe=0 ov=0",
                  ok, bus.rx_data, bus.rx_frame_err, bus.rx_overrun, e);
      end
   endtask

   initial begin
      bus.rx_ack = 1'b0;
      test_reset();
      test_good_frame();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_ack_coincident();
      test_reset_mid_frame();
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d bytes left want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side companion to the SoC's `uart` transmitter. It deserializes an 8N1 asynchronous serial stream on `rxd` into bytes and presents each byte through a one-entry holding register with a valid/ack handshake. Framing errors and overruns are reported to `memory_map`, which exposes the byte and flags to the Kronos core as a memory-mapped UART RX register.

## Interface
Parameters:
- `CLK_SPEED`, default 100_000_000: `clk` frequency in Hz.
- `BAUDRATE`, default 115200: line rate in bit/s.
- Derived: `CLKS_PER_BIT = CLK_SPEED / BAUDRATE` (integer division, truncated); `HALF_BIT = CLKS_PER_BIT / 2` (truncated). Elaboration error if `CLKS_PER_BIT < 4`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rstz`  in  1  reset, asynchronous and active-low.
- `rxd`  in  1  serial line, asynchronous to `clk`; idles high.
- `rx_data`  out  8  last good byte received.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ack`  in  1  consumer pulse; clears `rx_valid` and `rx_overrun`.
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `rx_overrun`  out  1  sticky; a good byte arrived while `rx_valid` was already 1 and `rx_ack` was not asserted.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- **Synchronizer:** two flops, `rxd` → `s1` → `s2`. Both reset to 1. All logic uses `s2` only.
- **Counter:** a bit counter sized for `CLKS_PER_BIT - 1` plus a 3-bit bit index.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** on `s2 == 0`, clear the counter and go to START.
  - **START:** at `counter == HALF_BIT - 1`:
    - if `s2 == 0`, clear counter and bit index, go to DATA;
    - otherwise it is a false start: go to IDLE and emit no flags.
  - **DATA:** at `counter == CLKS_PER_BIT - 1`:
    - shift `s2` into `shift[bit_index]`, LSB first, and clear the counter;
    - after bit 7, go to STOP.
  - **STOP:** at `counter == CLKS_PER_BIT - 1`, sample `s2`:
    - 1 (good frame): deliver the byte, go to IDLE.
    - 0 (bad frame): pulse `rx_frame_err`, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `s2 == 1`, then go to IDLE. A held-low break line therefore never restarts reception.
- **Delivery of a good byte:**
  - if `rx_valid == 0`, or `rx_ack` is asserted in the same cycle: load `rx_data`, set `rx_valid = 1`;
  - otherwise: keep the old `rx_data`, leave `rx_valid = 1`, set `rx_overrun = 1`.
- **`rx_ack`:**
  - any cycle with `rx_ack == 1` clears `rx_valid` unless a delivery occurs in that same cycle;
  - it clears `rx_overrun` whenever no new overrun occurs in that cycle;
  - `rx_ack` with `rx_valid == 0` has no effect.
- **Reset (`rstz` low, any time, including mid-frame):** state goes to IDLE, counters to 0, `rx_data = 0x00`, `rx_valid = 0`, `rx_frame_err = 0`, `rx_overrun = 0`, `rx_busy = 0`, synchronizer flops to 1. A partial frame in progress is lost.

## Timing
- The synchronizer adds 2 cycles of latency from the `rxd` pin to `s2`.
- Let T0 be the cycle in which IDLE sees `s2 == 0`:
  - start-bit check at T0 + `HALF_BIT`;
  - data bit n sampled at T0 + `HALF_BIT` + (n+1)·`CLKS_PER_BIT`, for n = 0..7;
  - stop bit sampled at T0 + `HALF_BIT` + 9·`CLKS_PER_BIT`.
- `rx_valid`, `rx_data`, `rx_frame_err` and `rx_overrun` are registered. They change in the cycle after the stop sample.
- The block returns to IDLE mid-stop-bit, so a start bit immediately following a stop bit is caught. This tolerates back-to-back frames with no idle gap.
- `rx_busy` rises the cycle after T0. It falls the cycle after the FSM leaves STOP (good frame) or WAIT_HIGH (bad frame).
- Tolerated baud mismatch: ±(`HALF_BIT` − 1)/(9.5·`CLKS_PER_BIT`) relative.

## Test plan
All scenarios use `CLK_SPEED = 1_600_000` and `BAUDRATE = 100_000`, giving `CLKS_PER_BIT = 16` and `HALF_BIT = 8`.
- **Good frame:** send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop). Expect `rx_valid` = 1 and `rx_data` = 0xA5 exactly 2 + 8 + 9·16 + 1 cycles after the falling edge of `rxd`, with `rx_frame_err` = 0 and `rx_overrun` = 0. Then `rx_ack` for 1 cycle: expect `rx_valid` = 0 on the next cycle.
- **Glitch:** drive `rxd` low for 4 cycles, then high. Expect `rx_busy` to pulse for 8 cycles, `rx_valid` = 0, and no flags.
- **Framing error and break:** send 0x3C with the stop bit low, then hold `rxd` low for 40 cycles, then high. Expect one 1-cycle `rx_frame_err` pulse and `rx_valid` = 0, with `rx_busy` high through the low period. A following 0x55 frame is received correctly.
- **Overrun:** send 0x01 and 0x02 back-to-back with no ack. Expect `rx_data` = 0x01, `rx_valid` = 1, `rx_overrun` = 1. Then `rx_ack`: expect `rx_valid` = 0 and `rx_overrun` = 0.
- **Ack coincident with delivery:** hold `rx_ack` high on exactly the delivery cycle of the second byte 0x02. Expect `rx_data` = 0x02, `rx_valid` = 1, `rx_overrun` = 0.
- **Reset mid-frame:** pull `rstz` low during data bit 3 of 0x7E. Expect all outputs at reset values immediately (asynchronous) and no delivery. After release, with the line idle and then a full 0xC3 frame sent, expect `rx_data` = 0xC3 with no flags.
